// File: rtl/disp_scan_pkg.sv
`default_nettype none
// +-- disp_pkg | shared codes, glyphs and digit-to-field map for the display scanner --+
// +-- rev 1.0                                                                          --+
package disp_pkg;

  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,
    SEL_SEC   = 3'd1,
    SEL_MIN   = 3'd2,
    SEL_HOUR  = 3'd3,
    SEL_DAY   = 3'd4,
    SEL_MONTH = 3'd5,
    SEL_YEAR  = 3'd6,
    SEL_RSVD  = 3'd7
  } sel_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Code 7 is reserved and behaves exactly like "nothing selected".
  function automatic sel_e norm_sel(input logic [2:0] raw);
    return (raw == 3'd7) ? SEL_NONE : sel_e'(raw);
  endfunction

  function automatic logic eff_page(input sel_e sel, input logic stored);
    case (sel)
      SEL_SEC, SEL_MIN, SEL_HOUR:    return 1'b0;
      SEL_DAY, SEL_MONTH, SEL_YEAR:  return 1'b1;
      default:                       return stored;
    endcase
  endfunction

  // Which editable field owns a digit position; dashes belong to no field.
  function automatic sel_e digit_field(input logic date_pg, input logic [2:0] idx);
    if (!date_pg) begin
      case (idx)
        3'd7, 3'd6: return SEL_HOUR;
        3'd4, 3'd3: return SEL_MIN;
        3'd1, 3'd0: return SEL_SEC;
        default:    return SEL_NONE;
      endcase
    end else begin
      case (idx)
        3'd7, 3'd6: return SEL_DAY;
        3'd5, 3'd4: return SEL_MONTH;
        default:    return SEL_YEAR;
      endcase
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/disp_scan_if.sv
`default_nettype none
// +-- disp_scan_if | calendar fields in, multiplexed seven-segment drive out --+
// +-- rev 1.0                                                                  --+
interface disp_scan_if;
  logic        page_tgl;
  logic [2:0]  select_item;
  logic [7:0]  bcd_ss;
  logic [7:0]  bcd_mm;
  logic [7:0]  bcd_hh;
  logic [7:0]  bcd_dd;
  logic [7:0]  bcd_mo;
  logic [15:0] bcd_yyyy;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [7:0]  an_n;

  modport master (
    output page_tgl, select_item, bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo, bcd_yyyy,
    input  seg_n, dp_n, an_n
  );

  modport slave (
    input  page_tgl, select_item, bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo, bcd_yyyy,
    output seg_n, dp_n, an_n
  );
endinterface
`default_nettype wire

// File: rtl/disp_scan_seg7_dec.sv
`default_nettype none
// +-- seg7_dec | BCD digit to active-low a..g segments, blank above 9 --+
// +-- rev 1.0                                                          --+
module seg7_dec
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/disp_scan.sv
`default_nettype none
// +-- disp_scan | 8-digit common-anode scan driver: time/date pages, edit-field blink --+
// +-- rev 1.0                                                                          --+
module disp_scan
  import disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50_000,
  parameter int BLANK     = 16,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  disp_scan_if.slave bus
);
  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         digit_idx;
  logic               page;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_ph;
  logic [2:0]         sel_q;
  logic               rst_q;
  logic [7:0]         sh_ss, sh_mm, sh_hh, sh_dd, sh_mo;
  logic [15:0]        sh_yyyy;
  logic [7:0]         an_q;
  logic [6:0]         seg_q;
  logic               dp_q;

  logic       scan_wrap, frame_wrap, blink_wrap, sel_chg;
  sel_e       sel_eff;
  logic       disp_page;
  logic [3:0] nib;
  logic       dash, dp_on, blink_hit;
  logic [6:0] dec_seg, nxt_seg;
  logic [7:0] nxt_an;

  assign scan_wrap  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign frame_wrap = scan_wrap && (digit_idx == 3'd7);
  assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
  assign sel_chg    = (bus.select_item != sel_q);
  assign sel_eff    = norm_sel(bus.select_item);
  assign disp_page  = eff_page(sel_eff, page);

  always_comb begin
    nib   = 4'hF;
    dash  = 1'b0;
    dp_on = 1'b0;
    if (!disp_page) begin
      case (digit_idx)
        3'd7:    nib = sh_hh[7:4];
        3'd6:    nib = sh_hh[3:0];
        3'd4:    nib = sh_mm[7:4];
        3'd3:    nib = sh_mm[3:0];
        3'd1:    nib = sh_ss[7:4];
        3'd0:    nib = sh_ss[3:0];
        default: dash = 1'b1;
      endcase
    end else begin
      case (digit_idx)
        3'd7:    nib = sh_dd[7:4];
        3'd6:    begin nib = sh_dd[3:0]; dp_on = 1'b1; end
        3'd5:    nib = sh_mo[7:4];
        3'd4:    begin nib = sh_mo[3:0]; dp_on = 1'b1; end
        3'd3:    nib = sh_yyyy[15:12];
        3'd2:    nib = sh_yyyy[11:8];
        3'd1:    nib = sh_yyyy[7:4];
        default: nib = sh_yyyy[3:0];
      endcase
    end
  end

  seg7_dec u_dec (
    .bcd (nib),
    .seg (dec_seg)
  );

  // Blink blanks segments only; the anode keeps its normal timing.
  assign blink_hit = blink_ph && (sel_eff != SEL_NONE) &&
                     (digit_field(disp_page, digit_idx) == sel_eff);
  assign nxt_seg   = blink_hit ? SEG_BLANK : (dash ? SEG_DASH : dec_seg);
  assign nxt_an    = (scan_cnt >= SCAN_W'(BLANK)) ? ~(8'd1 << digit_idx) : 8'hFF;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      page      <= 1'b0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      sel_q     <= '0;
      rst_q     <= 1'b1;
      sh_ss     <= '0;
      sh_mm     <= '0;
      sh_hh     <= '0;
      sh_dd     <= '0;
      sh_mo     <= '0;
      sh_yyyy   <= '0;
      an_q      <= 8'hFF;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      sel_q <= bus.select_item;

      if (scan_wrap) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        scan_cnt  <= scan_cnt + 1'b1;
      end

      // Restart the blink phase on every selector change so a new field starts visible.
      if (sel_chg) begin
        blink_cnt <= '0;
        blink_ph  <= 1'b0;
      end else if (blink_wrap) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      if (bus.page_tgl && (sel_eff == SEL_NONE)) page <= ~page;

      if (frame_wrap || rst_q) begin
        sh_ss   <= bus.bcd_ss;
        sh_mm   <= bus.bcd_mm;
        sh_hh   <= bus.bcd_hh;
        sh_dd   <= bus.bcd_dd;
        sh_mo   <= bus.bcd_mo;
        sh_yyyy <= bus.bcd_yyyy;
      end

      an_q  <= nxt_an;
      seg_q <= nxt_seg;
      dp_q  <= ~(dp_on && !blink_hit);
    end
  end

  assign bus.an_n  = an_q;
  assign bus.seg_n = seg_q;
  assign bus.dp_n  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan.sv
`default_nettype none
// +-- tb_disp_scan | scoreboard bench: per-cycle expected frame pushed, popped after each edge --+
// +-- rev 1.0                                                                                   --+
module tb_disp_scan;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK     = 2;
  localparam int BLINK_DIV = 64;
  localparam int FRAME     = 8 * SCAN_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  disp_scan_if bus ();

  disp_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK     (BLANK),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       chk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: edges since reset release, blink origin, stored page, frame shadows.
  int         n;
  int         origin;
  logic       page_m;
  logic [2:0] sel_prev;
  logic [7:0] m_ss, m_mm, m_hh, m_dd, m_mo;
  logic [15:0] m_yyyy;

  function automatic logic [2:0] eff_sel(input logic [2:0] s);
    return (s == 3'd7) ? 3'd0 : s;
  endfunction

  function automatic logic pg_of(input logic [2:0] s, input logic pg);
    if (s >= 3'd1 && s <= 3'd3) return 1'b0;
    if (s >= 3'd4 && s <= 3'd6) return 1'b1;
    return pg;
  endfunction

  function automatic logic [2:0] field_of(input logic pg, input int d);
    if (!pg) begin
      case (d)
        7, 6:    return 3'd3;
        4, 3:    return 3'd2;
        1, 0:    return 3'd1;
        default: return 3'd0;
      endcase
    end
    case (d)
      7, 6:    return 3'd4;
      5, 4:    return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic exp_t expect_now(input int cnt, input logic [2:0] s);
    exp_t       e;
    int         sl, d;
    logic       pg, ph;
    logic [2:0] es;
    sl = cnt % SCAN_DIV;
    d  = (cnt / SCAN_DIV) % 8;
    es = eff_sel(s);
    pg = pg_of(es, page_m);
    ph = (((cnt - origin) / BLINK_DIV) % 2) == 1;
    e.an  = (sl >= BLANK) ? ~(8'd1 << d) : 8'hFF;
    e.chk = (sl >= BLANK);
    e.dp  = 1'b1;
    e.seg = 7'h7F;
    if (!pg) begin
      case (d)
        7: e.seg = glyph(m_hh[7:4]);
        6: e.seg = glyph(m_hh[3:0]);
        4: e.seg = glyph(m_mm[7:4]);
        3: e.seg = glyph(m_mm[3:0]);
        1: e.seg = glyph(m_ss[7:4]);
        0: e.seg = glyph(m_ss[3:0]);
        default: e.seg = 7'h3F;
      endcase
    end else begin
      case (d)
        7: e.seg = glyph(m_dd[7:4]);
        6: e.seg = glyph(m_dd[3:0]);
        5: e.seg = glyph(m_mo[7:4]);
        4: e.seg = glyph(m_mo[3:0]);
        default: e.seg = glyph(m_yyyy[4*d +: 4]);
      endcase
      e.dp = !(d == 6 || d == 4);
    end
    if (ph && es != 3'd0 && field_of(pg, d) == es) begin
      e.seg = 7'h7F;
      e.dp  = 1'b1;
    end
    return e;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s scoreboard: observed empty queue, expected an entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      assert (bus.an_n === e.an) else begin
        errors++;
        $error("FAIL %s an_n @%0d: observed %h expected %h", tag, n, bus.an_n, e.an);
      end
      if (e.chk) begin
        checks += 2;
        assert (bus.seg_n === e.seg) else begin
          errors++;
          $error("FAIL %s seg_n @%0d: observed %h expected %h", tag, n, bus.seg_n, e.seg);
        end
        assert (bus.dp_n === e.dp) else begin
          errors++;
          $error("FAIL %s dp_n @%0d: observed %b expected %b", tag, n, bus.dp_n, e.dp);
        end
      end
    end
  endtask

  task automatic run(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      sb.push_back(expect_now(n, bus.select_item));
      @(posedge clk);
      #1;
      n++;
      compare(tag);
      if (bus.select_item != sel_prev) begin
        origin   = n;
        sel_prev = bus.select_item;
      end
      if (bus.page_tgl && eff_sel(bus.select_item) == 3'd0) page_m = ~page_m;
      if (n == 1 || (n % FRAME) == 0) begin
        m_ss = bus.bcd_ss;  m_mm = bus.bcd_mm;  m_hh = bus.bcd_hh;
        m_dd = bus.bcd_dd;  m_mo = bus.bcd_mo;  m_yyyy = bus.bcd_yyyy;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      checks += 3;
      assert (bus.an_n === 8'hFF) else begin
        errors++;
        $error("FAIL reset an_n: observed %h expected ff", bus.an_n);
      end
      assert (bus.seg_n === 7'h7F) else begin
        errors++;
        $error("FAIL reset seg_n: observed %h expected 7f", bus.seg_n);
      end
      assert (bus.dp_n === 1'b1) else begin
        errors++;
        $error("FAIL reset dp_n: observed %b expected 1", bus.dp_n);
      end
    end
    rst      = 1'b0;
    n        = 0;
    origin   = 0;
    page_m   = 1'b0;
    sel_prev = 3'd0;
    m_ss = '0;  m_mm = '0;  m_hh = '0;  m_dd = '0;  m_mo = '0;  m_yyyy = '0;
    sb.delete();
  endtask

  initial begin
    bus.page_tgl    = 1'b0;
    bus.select_item = 3'd0;
    bus.bcd_hh      = 8'h12;
    bus.bcd_mm      = 8'h34;
    bus.bcd_ss      = 8'h56;
    bus.bcd_dd      = 8'h29;
    bus.bcd_mo      = 8'h02;
    bus.bcd_yyyy    = 16'h2024;

    do_reset(3);
    run(FRAME, "time_page");

    bus.page_tgl = 1'b1;  run(1, "page_tgl");
    bus.page_tgl = 1'b0;  run(FRAME - 1, "date_page");

    bus.select_item = 3'd3;  run(3 * FRAME, "blink_hour");

    // Selector back to 0 with a coincident toggle: the toggle is honoured.
    bus.select_item = 3'd0;  bus.page_tgl = 1'b1;  run(1, "sel0_tgl");
    bus.page_tgl = 1'b0;     run(FRAME - 1, "back_time");

    bus.select_item = 3'd5;  run(10, "force_date");
    bus.page_tgl = 1'b1;     run(1, "tgl_ignored");
    bus.page_tgl = 1'b0;     run(2 * FRAME - 11, "blink_month");

    bus.select_item = 3'd6;  bus.page_tgl = 1'b1;  run(1, "sel_tgl_coinc");
    bus.page_tgl = 1'b0;     run(FRAME - 1, "year_sel");

    bus.select_item = 3'd7;  run(FRAME, "sel7_as_none");
    bus.select_item = 3'd0;  run(FRAME, "restore_page");

    // Input change part-way through the minute digits must wait for the next frame.
    run(28, "pre_change");
    bus.bcd_ss = 8'h07;
    bus.bcd_mm = 8'h3C;
    run(FRAME - 28, "hold_old");
    run(FRAME, "show_new");

    run(36, "to_digit4");
    do_reset(1);
    run(FRAME, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp_scan.md
# disp_scan

Time-multiplexed seven-segment driver downstream of the clock/calendar counter. Consumes the six packed-BCD fields (ss, mm, hh, dd, mo, yyyy) plus the edit-field selector, and drives an 8-digit common-anode display. It shows a time page or a date page, and blinks the field currently being edited. Runs on the fast system clock, not the 1 Hz tick.

## Interface
- SCAN_DIV, 50_000: clock cycles per digit slot; ≥ BLANK+2.
- BLANK, 16: cycles at slot start with all anodes off (anti-ghosting).
- BLINK_DIV, 12_500_000: cycles per blink phase.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- page_tgl  in  1  one-cycle pulse; toggles time/date page.
- select_item  in  3  edit field: 0 none, 1 sec, 2 min, 3 hour, 4 day, 5 month, 6 year, 7 treated as 0.
- bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo  in  8 each  two BCD digits each, tens in [7:4].
- bcd_yyyy  in  16  four BCD digits, thousands in [15:12].
- seg_n  out  7  segments a..g, active-low, a = bit 0.
- dp_n  out  1  decimal point, active-low.
- an_n  out  8  digit enables, active-low; bit 7 is the leftmost digit.

## Operation
- scan_cnt counts 0..SCAN_DIV-1, then wraps. On wrap, digit_idx increments 0..7 and wraps to 0.
- Frame snapshot: all BCD inputs are loaded into shadow registers on the cycle digit_idx wraps 7→0, and also during reset release. Display always reads the shadows, so there is no tearing within a frame.
- Page 0 (time), digits 7..0: H1 H0 '-' M1 M0 '-' S1 S0. Dash is segment g only. No dp.
- Page 1 (date), digits 7..0: D1 D0 Mo1 Mo0 Y3 Y2 Y1 Y0. dp lit on digits 6 and 4.
- Page register toggles on page_tgl only while select_item = 0.
- Effective page is forced to 0 for select_item 1–3 and to 1 for select_item 4–6. The page register itself is unchanged.
- Blink: blink_cnt counts 0..BLINK_DIV-1. blink_ph toggles on wrap.
  - Any change of select_item clears blink_cnt and blink_ph in that cycle.
  - When blink_ph = 1 and the current digit belongs to the selected field, seg_n = 7'h7F and dp_n = 1. The anode is still driven.
- BCD nibble > 9 displays blank.
- Decoding of 0–9 uses the standard a..g patterns (0 = 7'h40 active-low, 8 = 7'h00).

## Timing
- Reset values: an_n = 8'hFF, seg_n = 7'h7F, dp_n = 1, scan_cnt = 0, digit_idx = 0, page = 0, blink_cnt = 0, blink_ph = 0, shadows = 0.
- All outputs are registered, with 1-cycle latency from scan_cnt/digit_idx state.
- Within a slot, an_n[digit_idx] is low for scan_cnt in BLANK..SCAN_DIV-1, as seen one cycle later at the outputs. All anodes are high otherwise.
- seg_n and dp_n are updated in the same cycle as an_n.
- Frame period is 8·SCAN_DIV cycles. Snapshot-to-display latency is at most one frame.
- page_tgl coincident with a select_item change: the select_item rule wins, so the toggle is ignored if the new select_item ≠ 0.
- rst mid-frame: the next cycle equals the reset state, and scanning restarts at digit 0.

## Structure
- Package disp_pkg holds:
  - select_item codes (SEL_NONE..SEL_YEAR);
  - seven-segment constants SEG_BLANK and SEG_DASH;
  - the digit-to-field map per page.
- Sub-module seg7_dec: combinational 4-bit BCD → 7-bit active-low segments, blank for values > 9.
- Top: scan counter, blink counter, page register, shadow registers, digit mux, output registers.

## Test plan
Benches use SCAN_DIV = 8, BLANK = 2, BLINK_DIV = 64.
- Reset, then run 64 cycles with hh:mm:ss = 12:34:56 → an_n cycles FE, FD, … 7F. Each is active for 6 of 8 cycles, with 2 all-high cycles per slot. Digit 7 shows "1" (seg_n 7'h79) and digits 5 and 2 show dash (7'h3F).
- Single page_tgl with dd.mo.yyyy = 29.02.2024 → the next frame shows 2 9 0 2 2 0 2 4, with dp_n = 0 on digits 6 and 4 only.
- select_item = 3 → hour digits blank during blink_ph = 1 (cycles 64–127 after the change) while their anodes stay active. Other digits are unaffected.
- select_item = 5 while on page 0 → date page forced immediately. page_tgl pulses are ignored. Returning to 0 restores the stored page.
- Change bcd_ss mid-frame → the displayed ss changes only after the next 7→0 digit wrap.
- Assert rst during digit 4 → next cycle an_n = 8'hFF, and digit 0 is the first to activate, at cycle BLANK+1.
